// File: rtl/wb_stage_pipe.sv
// -----------------------------------------------------------------------------
// wb_stage_pipe
//
// Writeback stage of the pipelined WISC core. Owns the MEM/WB pipeline
// register, waits for a multi-cycle data memory on loads, and commits exactly
// one register-file write per retired instruction.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/ready    handshake from the memory stage
//   in_alu_result     ALU output
//   in_pc_plus2       link value for JAL/JALR
//   in_imm            immediate for LBI/SLBI
//   in_wb_sel         result source: 00 ALU, 01 MEM, 10 PC+2, 11 IMM
//   in_reg_write      instruction writes a register
//   in_write_reg      destination register
//   in_halt           instruction is HALT
//   mem_rdata         load data, valid while mem_done=1
//   mem_done          single-cycle pulse: load data available
//   wb_reg_write      register-file write enable (COMMIT only)
//   wb_write_reg      register-file write address
//   wb_result         register-file write data / decode forwarding value
//   halted            sticky, HALT retired
//   retire_count      instructions retired since reset (wraps)
// -----------------------------------------------------------------------------
module wb_stage_pipe #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_alu_result,
   input  logic [DATA_W-1:0] in_pc_plus2,
   input  logic [DATA_W-1:0] in_imm,
   input  logic [1:0]        in_wb_sel,
   input  logic              in_reg_write,
   input  logic [REG_AW-1:0] in_write_reg,
   input  logic              in_halt,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              wb_reg_write,
   output logic [REG_AW-1:0] wb_write_reg,
   output logic [DATA_W-1:0] wb_result,
   output logic              halted,
   output logic [CNT_W-1:0]  retire_count
);

   localparam logic [1:0] ST_EMPTY    = 2'd0;
   localparam logic [1:0] ST_WAIT_MEM = 2'd1;
   localparam logic [1:0] ST_COMMIT   = 2'd2;
   localparam logic [1:0] ST_HALTED   = 2'd3;

   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_PC2 = 2'b10;

   logic [1:0]        state_q, state_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] pc2_q, pc2_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic [DATA_W-1:0] mdata_q, mdata_d;
   logic [1:0]        sel_q, sel_d;
   logic              rw_q, rw_d;
   logic [REG_AW-1:0] wr_q, wr_d;
   logic              halt_q, halt_d;
   logic [CNT_W-1:0]  count_q, count_d;

   logic in_commit;
   logic accept;
   logic is_load;

   assign in_commit = (state_q == ST_COMMIT);
   assign in_ready  = (state_q == ST_EMPTY) || in_commit;
   // While a HALT is committing the handshake still reads ready, but whatever
   // is offered in that cycle is dropped and never retires.
   assign accept    = in_valid && in_ready && !(in_commit && halt_q);
   assign is_load   = (in_wb_sel == SEL_MEM);

   always_comb begin
      state_d = state_q;
      alu_d   = alu_q;
      pc2_d   = pc2_q;
      imm_d   = imm_q;
      mdata_d = mdata_q;
      sel_d   = sel_q;
      rw_d    = rw_q;
      wr_d    = wr_q;
      halt_d  = halt_q;
      count_d = count_q;

      if (in_commit) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end

      case (state_q)
         ST_EMPTY, ST_COMMIT: begin
            if (in_commit && halt_q) begin
               state_d = ST_HALTED;
            end else if (accept) begin
               alu_d  = in_alu_result;
               pc2_d  = in_pc_plus2;
               imm_d  = in_imm;
               sel_d  = in_wb_sel;
               rw_d   = in_reg_write;
               wr_d   = in_write_reg;
               halt_d = in_halt;
               // A load whose data arrives in its own capture cycle skips
               // WAIT_MEM entirely.
               if (is_load && mem_done) begin
                  mdata_d = mem_rdata;
               end
               state_d = (is_load && !mem_done) ? ST_WAIT_MEM : ST_COMMIT;
            end else begin
               state_d = ST_EMPTY;
            end
         end
         ST_WAIT_MEM: begin
            if (mem_done) begin
               mdata_d = mem_rdata;
               state_d = ST_COMMIT;
            end
         end
         default: state_d = ST_HALTED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
         alu_q   <= '0;
         pc2_q   <= '0;
         imm_q   <= '0;
         mdata_q <= '0;
         sel_q   <= '0;
         rw_q    <= 1'b0;
         wr_q    <= '0;
         halt_q  <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         alu_q   <= alu_d;
         pc2_q   <= pc2_d;
         imm_q   <= imm_d;
         mdata_q <= mdata_d;
         sel_q   <= sel_d;
         rw_q    <= rw_d;
         wr_q    <= wr_d;
         halt_q  <= halt_d;
         count_q <= count_d;
      end
   end

   // Result mux is driven only from the holding register, so the forwarded
   // value never depends combinationally on the memory-stage inputs.
   always_comb begin
      case (sel_q)
         SEL_ALU: wb_result = alu_q;
         SEL_MEM: wb_result = mdata_q;
         SEL_PC2: wb_result = pc2_q;
         default: wb_result = imm_q;
      endcase
   end

   assign wb_reg_write = in_commit && rw_q;
   assign wb_write_reg = wr_q;
   assign halted       = (state_q == ST_HALTED);
   assign retire_count = count_q;

endmodule

// File: tb/tb_wb_stage_pipe.sv
module tb_wb_stage_pipe;
   localparam int DW = 16;
   localparam int AW = 3;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_alu_result, in_pc_plus2, in_imm;
   logic [1:0]    in_wb_sel;
   logic          in_reg_write;
   logic [AW-1:0] in_write_reg;
   logic          in_halt;
   logic [DW-1:0] mem_rdata;
   logic          mem_done;
   logic          wb_reg_write;
   logic [AW-1:0] wb_write_reg;
   logic [DW-1:0] wb_result;
   logic          halted;
   logic [CW-1:0] retire_count;

   wb_stage_pipe #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_pc_plus2(in_pc_plus2), .in_imm(in_imm),
      .in_wb_sel(in_wb_sel), .in_reg_write(in_reg_write), .in_write_reg(in_write_reg),
      .in_halt(in_halt), .mem_rdata(mem_rdata), .mem_done(mem_done),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg), .wb_result(wb_result),
      .halted(halted), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   // Reference model: which instruction (if any) retires this cycle, a load
   // parked waiting for data, the sticky halt flag and a plain retire tally.
   bit            c_v, c_rw, c_halt;
   logic [AW-1:0] c_wr;
   logic [DW-1:0] c_data;
   bit            w_pend, p_rw, p_halt;
   logic [AW-1:0] p_wr;
   bit            m_halted;
   int            m_count;

   int vectors = 0;
   int miscompares = 0;
   int checks = 0;

   function automatic logic [DW-1:0] pick(input logic [1:0] sel, input logic [DW-1:0] alu,
                                          input logic [DW-1:0] mem, input logic [DW-1:0] pc,
                                          input logic [DW-1:0] imm);
      if (sel == 2'd0) return alu;
      if (sel == 2'd1) return mem;
      if (sel == 2'd2) return pc;
      return imm;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      c_v = 0; c_rw = 0; c_halt = 0; c_wr = '0; c_data = '0;
      w_pend = 0; p_rw = 0; p_halt = 0; p_wr = '0;
      m_halted = 0; m_count = 0;
   endtask

   task automatic set_in(input bit v, input logic [1:0] sel, input logic [DW-1:0] alu,
                         input logic [DW-1:0] pc, input logic [DW-1:0] imm, input bit rw,
                         input logic [AW-1:0] wr, input bit hlt, input bit md,
                         input logic [DW-1:0] mdat);
      in_valid = v; in_wb_sel = sel; in_alu_result = alu; in_pc_plus2 = pc;
      in_imm = imm; in_reg_write = rw; in_write_reg = wr; in_halt = hlt;
      mem_done = md; mem_rdata = mdat;
   endtask

   task automatic set_idle();
      set_in(0, 2'd0, '0, '0, '0, 0, '0, 0, 0, '0);
   endtask

   task automatic check_outputs();
      chk("in_ready", 32'(!m_halted && !w_pend), 32'(in_ready));
      chk("wb_reg_write", 32'(wb_reg_write), 32'(c_v && c_rw));
      if (c_v && c_rw) begin
         chk("wb_write_reg", 32'(wb_write_reg), 32'(c_wr));
         chk("wb_result", 32'(wb_result), 32'(c_data));
      end
      chk("halted", 32'(halted), 32'(m_halted));
      chk("retire_count", 32'(retire_count), 32'(m_count % (1 << CW)));
   endtask

   // Check the current cycle, advance the model using the inputs now driven,
   // then step one clock.
   task automatic cycle();
      bit            n_v, n_rw, n_halt;
      logic [AW-1:0] n_wr;
      logic [DW-1:0] n_data;
      check_outputs();
      n_v = 0; n_rw = 0; n_halt = 0; n_wr = '0; n_data = '0;
      if (c_v) m_count++;
      if (!m_halted) begin
         if (c_v && c_halt) begin
            m_halted = 1;
         end else if (w_pend) begin
            if (mem_done) begin
               n_v = 1; n_rw = p_rw; n_wr = p_wr; n_halt = p_halt; n_data = mem_rdata;
               w_pend = 0;
            end
         end else if (in_valid) begin
            if (in_wb_sel == 2'd1 && !mem_done) begin
               w_pend = 1; p_rw = in_reg_write; p_wr = in_write_reg; p_halt = in_halt;
            end else begin
               n_v = 1; n_rw = in_reg_write; n_wr = in_write_reg; n_halt = in_halt;
               n_data = pick(in_wb_sel, in_alu_result, mem_rdata, in_pc_plus2, in_imm);
            end
         end
      end
      vectors++;
      @(posedge clk);
      #1;
      c_v = n_v; c_rw = n_rw; c_wr = n_wr; c_data = n_data; c_halt = n_halt;
   endtask

   initial begin
      // Reset values
      rst = 1'b1;
      set_idle();
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
      chk("rst_wb_write_reg", 32'(wb_write_reg), 32'd0);
      chk("rst_wb_result", 32'(wb_result), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_retire_count", 32'(retire_count), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // Back-to-back ALU ops
      set_in(1, 2'd0, 16'h1234, 16'h0, 16'h0, 1, 3'd1, 0, 0, 16'h0); cycle();
      set_in(1, 2'd0, 16'h00FF, 16'h0, 16'h0, 1, 3'd2, 0, 0, 16'h0); cycle();
      set_idle(); cycle();
      chk("count_after_two_alu", 32'(retire_count), 32'd2);

      // Load, data three cycles after transfer, then a stray mem_done
      set_in(1, 2'd1, 16'h1111, 16'h2222, 16'h3333, 1, 3'd5, 0, 0, 16'h0); cycle();
      set_idle(); cycle();
      cycle();
      set_in(0, 2'd0, '0, '0, '0, 0, '0, 0, 1, 16'hBEEF); cycle();
      set_idle(); cycle();
      set_in(0, 2'd0, '0, '0, '0, 0, '0, 0, 1, 16'hDEAD); cycle();
      set_idle(); cycle();
      cycle();

      // PC+2 and IMM sources, then a non-writing op that still retires
      set_in(1, 2'd2, 16'hAAAA, 16'h0042, 16'h5555, 1, 3'd3, 0, 0, 16'h0); cycle();
      set_in(1, 2'd3, 16'hAAAA, 16'h0042, 16'hFFF0, 1, 3'd4, 0, 0, 16'h0); cycle();
      set_in(1, 2'd0, 16'h7777, 16'h0, 16'h0, 0, 3'd6, 0, 0, 16'h0); cycle();
      set_idle(); cycle();
      cycle();

      // Load with data in the capture cycle
      set_in(1, 2'd1, 16'h0, 16'h0, 16'h0, 1, 3'd7, 0, 1, 16'hC0DE); cycle();
      set_idle(); cycle();

      // Reset while a load is waiting
      set_in(1, 2'd1, 16'h0, 16'h0, 16'h0, 1, 3'd6, 0, 0, 16'h0); cycle();
      set_idle();
      #2 rst = 1'b1;
      #1;
      chk("midrst_wb_reg_write", 32'(wb_reg_write), 32'd0);
      chk("midrst_wb_write_reg", 32'(wb_write_reg), 32'd0);
      chk("midrst_wb_result", 32'(wb_result), 32'd0);
      chk("midrst_retire_count", 32'(retire_count), 32'd0);
      @(posedge clk); #1;
      set_in(0, 2'd0, '0, '0, '0, 0, '0, 0, 1, 16'h9999);
      rst = 1'b0;
      model_reset();
      cycle();
      set_idle(); cycle();

      // Counter wrap: 17 retirements on a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         set_in(1, 2'(i % 4 == 1 ? 0 : i % 4), 16'($urandom), 16'($urandom), 16'($urandom),
                1, 3'($urandom), 0, 0, 16'h0);
         cycle();
      end
      set_idle(); cycle();
      cycle();
      chk("count_wrap", 32'(retire_count), 32'd1);

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         set_in(bit'($urandom_range(0, 3) != 0), 2'($urandom), 16'($urandom), 16'($urandom),
                16'($urandom), bit'($urandom), 3'($urandom), 0,
                bit'($urandom_range(0, 2) == 0), 16'($urandom));
         cycle();
      end
      set_idle();
      for (int i = 0; i < 20 && w_pend; i++) begin
         mem_done = bit'($urandom_range(0, 1)); mem_rdata = 16'($urandom);
         cycle();
      end
      set_idle(); cycle();
      cycle();

      // Store-like op, then HALT with in_valid held high
      set_in(1, 2'd0, 16'h4321, 16'h0, 16'h0, 0, 3'd2, 0, 0, 16'h0); cycle();
      set_in(1, 2'd0, 16'h0, 16'h0, 16'h0, 0, 3'd0, 1, 0, 16'h0); cycle();
      for (int i = 0; i < 8; i++) begin
         set_in(1, 2'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1,
                3'($urandom), 0, bit'($urandom), 16'($urandom));
         cycle();
      end
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_ready", 32'(in_ready), 32'd0);
      chk("halt_count_frozen", 32'(retire_count), 32'(m_count % (1 << CW)));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
